demux8_reg: RTL
===============

Name: demux8_reg

Overview:
- Registered 1-to-8 demultiplexer with valid/ready handshakes.
- Routes one input stream to one of eight output channels selected by a 3-bit select; the inverse of the 8:1 select mux used on the datapath.
- Each channel has a one-entry holding slot, so a stalled consumer blocks only its own channel.
- Sits between a producer stage (e.g. writeback/result router) and up to eight consumer units.

Parameters:
- DATA_WIDTH, 32, width of data word per channel.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous clear of all channel slots.
- in_valid  input  1  producer has a word.
- in_ready  output  1  word accepted this cycle when in_valid && in_ready.
- in_select  input  3  destination channel 0..7.
- in_data  input  DATA_WIDTH  word to route.
- out_valid  output  8  per-channel slot holds a word.
- out_ready  input  8  per-channel consumer accepts.
- out_data  output  8*DATA_WIDTH  packed; channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- ch_count  output  8*16  only with DEMUX8_COUNT_EN; channel k at [k*16 +: 16].

Behaviour:
- Reset (rst_n low, asynchronous):
  - out_valid = 8'h00 and all out_data = 0 immediately.
  - ch_count = 0 when the counter feature is enabled.
  - Reset mid-transfer discards all held words.
- in_ready (combinational) = !flush && (!out_valid[in_select] || out_ready[in_select]).
  - No dependence on in_valid.
- Accept: when in_valid && in_ready, on the next clk edge slot[in_select] loads in_data and out_valid[in_select] = 1.
  - Latency: exactly 1 cycle from accept to out_valid.
- Drain: when out_valid[k] && out_ready[k], out_valid[k] clears next edge, unless channel k is loaded in the same cycle.
  - A simultaneous drain and load on the same channel keeps out_valid[k] = 1 with the new word, giving a full-throughput pass-through.
- Unselected channels hold their data and valid unchanged. out_data[k] is stable while out_valid[k] && !out_ready[k].
- Producer rule: in_select and in_data must stay stable while in_valid && !in_ready. in_valid must not drop before acceptance.
- flush (synchronous, highest priority after reset):
  - Next edge: out_valid = 0.
  - in_ready = 0 during the flush cycle, so no accept.
  - out_data is not required to clear.
- Each slot is a 2-state machine:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on drain without load.
  - FULL -> FULL on drain+load or on hold.
  - Any state -> EMPTY on flush or reset.
- Channels are fully independent. At most one load per cycle, any number of drains per cycle.

Optional Feature:
- Macro DEMUX8_COUNT_EN.
- Defined:
  - Per-channel 16-bit counter of words accepted into that channel; increments on each load of channel k.
  - Wraps 16'hFFFF -> 0.
  - Cleared by reset; not cleared by flush.
  - Exposed on ch_count.
- Undefined: no counters and no ch_count port. Behaviour otherwise identical.

Decomposition:
- Package demux_pkg holds:
  - NUM_CH = 8, SEL_WIDTH = 3, CNT_WIDTH = 16.
  - typedef slot_state_t {EMPTY, FULL}.
- Sub-module demux_slot: one-entry holding register with load/drain/flush inputs, valid/data outputs and the optional counter.
  - Instantiated 8 times via generate.
  - Top level contains only select decode and in_ready logic.

Test Plan:
- Reset/idle: rst_n low mid-run with out_valid = 8'h24 -> out_valid = 8'h00 and out_data = 0 immediately, without waiting for clk; in_ready = 1 after release with all out_ready = 0.
- Single route: in_select = 5, in_data = 32'hDEADBEEF, out_ready = 0 -> next cycle out_valid = 8'h20, out_data[5] = DEADBEEF, held for 10 cycles.
- Backpressure: channel 5 full with out_ready[5] = 0, producer targets 5 -> in_ready = 0 until out_ready[5] = 1, then accept; a write to channel 2 meanwhile is accepted.
- Pass-through: out_ready = 8'hFF, stream 16 words to channel 3 -> in_ready always 1; out_valid[3] high for 16 consecutive cycles with data in order.
- Flush: channels 0, 1 and 7 full, assert flush for one cycle while in_valid = 1 -> in_ready = 0 that cycle; next cycle out_valid = 0; no word lost from the producer's view.
- Counter (DEMUX8_COUNT_EN): 65537 loads into channel 6 -> ch_count[6] = 1; other channels 0; flush leaves counts intact.

Source files
------------

// File: rtl/demux_pkg.sv
// Shared constants and slot state type for the registered 1-to-8 demultiplexer.
package demux_pkg;

    localparam int NUM_CH    = 8;
    localparam int SEL_WIDTH = 3;
    localparam int CNT_WIDTH = 16;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding slot for a single demux channel: load, drain and flush control.
// Optional per-slot accepted-word counter when DEMUX8_COUNT_EN is defined.
module demux_slot
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_load,
    input  logic                  i_drain,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
`ifdef DEMUX8_COUNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  o_count
`endif
);

    slot_state_t           r_state;
    slot_state_t           w_state_next;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  w_load;

    // Flush wins over a load; the top already blocks accepts during flush.
    assign w_load = i_load && !i_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (i_flush) begin
            w_state_next = EMPTY;
        end else if (w_load) begin
            w_state_next = FULL;
        end else if (i_drain) begin
            w_state_next = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
        end else if (w_load) begin
            r_data <= i_data;
        end
    end

    assign o_valid = (r_state == FULL);
    assign o_data  = r_data;

`ifdef DEMUX8_COUNT_EN
    logic [CNT_WIDTH-1:0] r_count;

    // Counts survive flush; only reset clears them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_load) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
`endif

endmodule

// File: rtl/demux8_reg.sv
// Registered 1-to-8 demultiplexer with valid/ready handshakes and per-channel holding slots.
// Optional per-channel load counters on ch_count when DEMUX8_COUNT_EN is defined.
module demux8_reg
    import demux_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEL_WIDTH-1:0]         in_select,
    input  logic [DATA_WIDTH-1:0]        in_data,
    output logic [NUM_CH-1:0]            out_valid,
    input  logic [NUM_CH-1:0]            out_ready,
    output logic [NUM_CH*DATA_WIDTH-1:0] out_data
`ifdef DEMUX8_COUNT_EN
    ,
    output logic [NUM_CH*CNT_WIDTH-1:0]  ch_count
`endif
);

    logic [NUM_CH-1:0] w_sel_onehot;
    logic [NUM_CH-1:0] w_load;
    logic [NUM_CH-1:0] w_drain;
    logic              w_accept;

    // Ready only looks at the selected channel, so a stalled consumer blocks nobody else.
    assign in_ready = !flush && (!out_valid[in_select] || out_ready[in_select]);
    assign w_accept = in_valid && in_ready;

    always_comb begin
        w_sel_onehot = '0;
        w_sel_onehot[in_select] = 1'b1;
    end

    assign w_load  = w_accept ? w_sel_onehot : '0;
    assign w_drain = out_valid & out_ready;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_slot
            demux_slot #(
                .DATA_WIDTH (DATA_WIDTH)
            ) u_slot (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_flush (flush),
                .i_load  (w_load[gi]),
                .i_drain (w_drain[gi]),
                .i_data  (in_data),
                .o_valid (out_valid[gi]),
                .o_data  (out_data[gi*DATA_WIDTH +: DATA_WIDTH])
`ifdef DEMUX8_COUNT_EN
                ,
                .o_count (ch_count[gi*CNT_WIDTH +: CNT_WIDTH])
`endif
            );
        end
    endgenerate

endmodule
